// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline flow controller: FSM state encodings,
// the NOP instruction word loaded on an if_id flush, and the zero-register id.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN   = 2'd0,
        CTRL_FLUSH = 2'd1,
        CTRL_HOLD  = 2'd2
    } ctrl_state_e;

    // addi x0, x0, 0 -- what if_id holds while flushed
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // x0 is hardwired, so it never creates a dependency
    localparam logic [4:0]  ZERO_REG = 5'd0;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and pipe_ctrl.
// master: the core side that raises requests; slave: the controller.
interface pipe_ctrl_if;

    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        hold_req_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic        ex_load_i;
    logic [4:0]  ex_rd_addr_i;

    logic        pc_jump_en_o;
    logic [31:0] pc_jump_addr_o;
    logic        pc_hold_o;
    logic        if_id_hold_o;
    logic        if_id_flush_o;
    logic        id_ex_flush_o;
    logic        hold_timeout_o;
    logic [1:0]  state_o;

    modport master (
        output jump_en_i, jump_addr_i, hold_req_i,
               id_rs1_addr_i, id_rs2_addr_i, ex_load_i, ex_rd_addr_i,
        input  pc_jump_en_o, pc_jump_addr_o, pc_hold_o, if_id_hold_o,
               if_id_flush_o, id_ex_flush_o, hold_timeout_o, state_o
    );

    modport slave (
        input  jump_en_i, jump_addr_i, hold_req_i,
               id_rs1_addr_i, id_rs2_addr_i, ex_load_i, ex_rd_addr_i,
        output pc_jump_en_o, pc_jump_addr_o, pc_hold_o, if_id_hold_o,
               if_id_flush_o, id_ex_flush_o, hold_timeout_o, state_o
    );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: flags when the load in ex writes a register that the
// instruction in id reads, so id must wait one cycle for the load data.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       ex_load_i,
    input  logic [4:0] ex_rd_addr_i,
    input  logic [4:0] id_rs1_addr_i,
    input  logic [4:0] id_rs2_addr_i,
    output logic       hazard_o
);

    logic rd_live_s;
    logic rs_match_s;

    // Compare the load destination against both id sources
    always_comb begin
        rd_live_s  = (ex_rd_addr_i != ZERO_REG);
        rs_match_s = (ex_rd_addr_i == id_rs1_addr_i) || (ex_rd_addr_i == id_rs2_addr_i);
        hazard_o   = ex_load_i && rd_live_s && rs_match_s;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline flow controller for the if -> id -> ex core.
// Priority each cycle: jump > hold > load-use. A three-state FSM
// (RUN/FLUSH/HOLD) stretches flushes after a taken jump and supervises
// hold duration, pulsing hold_timeout_o once a hold outlasts HOLD_MAX.
// Hold/flush/jump outputs are combinational from inputs and state.
// Build option: define LOAD_USE_DETECT_EN to enable load-use stalls.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned HOLD_MAX     = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_ctrl_if.slave  ctrl
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_MAX);
    localparam logic       FLUSH_MULTI = (FLUSH_CYCLES > 1);

    ctrl_state_e state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic        timeout_q, timeout_d;
    logic        fired_q, fired_d;

    logic        load_use_s;
    logic        pc_jump_en_s;
    logic        pc_hold_s;
    logic        if_id_hold_s;
    logic        if_id_flush_s;
    logic        id_ex_flush_s;

`ifdef LOAD_USE_DETECT_EN
    hazard_detect u_hazard_detect (
        .ex_load_i     (ctrl.ex_load_i),
        .ex_rd_addr_i  (ctrl.ex_rd_addr_i),
        .id_rs1_addr_i (ctrl.id_rs1_addr_i),
        .id_rs2_addr_i (ctrl.id_rs2_addr_i),
        .hazard_o      (load_use_s)
    );
`else
    // Loads are forwarded or stalled elsewhere; the comparator inputs are sunk
    logic unused_load_use_s;
    assign unused_load_use_s = ^{ctrl.ex_load_i, ctrl.ex_rd_addr_i,
                                 ctrl.id_rs1_addr_i, ctrl.id_rs2_addr_i};
    assign load_use_s = 1'b0;
`endif

    // Next-state, counter and output decode
    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        timeout_d     = 1'b0;
        fired_d       = fired_q;
        pc_jump_en_s  = 1'b0;
        pc_hold_s     = 1'b0;
        if_id_hold_s  = 1'b0;
        if_id_flush_s = 1'b0;
        id_ex_flush_s = 1'b0;

        case (state_q)
            CTRL_RUN: begin
                if (ctrl.jump_en_i) begin
                    // Redirect wins over any hold: PC must take the target now
                    pc_jump_en_s  = 1'b1;
                    if_id_flush_s = 1'b1;
                    id_ex_flush_s = 1'b1;
                    if (FLUSH_MULTI) begin
                        state_d     = CTRL_FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end else if (ctrl.hold_req_i) begin
                        state_d    = CTRL_HOLD;
                        hold_cnt_d = 8'd1;
                        fired_d    = 1'b0;
                    end else begin
                        state_d = CTRL_RUN;
                    end
                end else if (ctrl.hold_req_i) begin
                    pc_hold_s     = 1'b1;
                    if_id_hold_s  = 1'b1;
                    id_ex_flush_s = 1'b1;
                    state_d       = CTRL_HOLD;
                    hold_cnt_d    = 8'd1;
                    fired_d       = 1'b0;
                end else if (load_use_s) begin
                    // Single-cycle bubble; the load result is ready next cycle
                    pc_hold_s     = 1'b1;
                    if_id_hold_s  = 1'b1;
                    id_ex_flush_s = 1'b1;
                end else begin
                    state_d = CTRL_RUN;
                end
            end

            CTRL_FLUSH: begin
                // Flush beats hold on if_id, so only the PC honours hold here
                if_id_flush_s = 1'b1;
                id_ex_flush_s = 1'b1;
                pc_hold_s     = ctrl.hold_req_i;
                if (flush_cnt_q > 3'd1) begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end else begin
                    flush_cnt_d = 3'd0;
                    if (ctrl.hold_req_i) begin
                        state_d    = CTRL_HOLD;
                        hold_cnt_d = 8'd1;
                        fired_d    = 1'b0;
                    end else begin
                        state_d = CTRL_RUN;
                    end
                end
            end

            CTRL_HOLD: begin
                if (ctrl.hold_req_i) begin
                    pc_hold_s     = 1'b1;
                    if_id_hold_s  = 1'b1;
                    id_ex_flush_s = 1'b1;
                    if (hold_cnt_q != HOLD_LIMIT) begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end else begin
                        hold_cnt_d = hold_cnt_q;
                    end
                    // Still holding after HOLD_MAX counted cycles: report once
                    if ((hold_cnt_q == HOLD_LIMIT) && !fired_q) begin
                        timeout_d = 1'b1;
                        fired_d   = 1'b1;
                    end else begin
                        timeout_d = 1'b0;
                    end
                end else begin
                    state_d    = CTRL_RUN;
                    hold_cnt_d = 8'd0;
                    fired_d    = 1'b0;
                end
            end

            default: begin
                state_d     = CTRL_RUN;
                flush_cnt_d = 3'd0;
                hold_cnt_d  = 8'd0;
                fired_d     = 1'b0;
            end
        endcase
    end

    // FSM state, counters and registered timeout pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CTRL_RUN;
            flush_cnt_q <= 3'd0;
            hold_cnt_q  <= 8'd0;
            timeout_q   <= 1'b0;
            fired_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            timeout_q   <= timeout_d;
            fired_q     <= fired_d;
        end
    end

    // Outputs are forced low while reset is asserted, whatever the inputs do
    assign ctrl.pc_jump_en_o   = rst_n & pc_jump_en_s;
    assign ctrl.pc_jump_addr_o = (rst_n & pc_jump_en_s) ? ctrl.jump_addr_i : 32'h0000_0000;
    assign ctrl.pc_hold_o      = rst_n & pc_hold_s;
    assign ctrl.if_id_hold_o   = rst_n & if_id_hold_s;
    assign ctrl.if_id_flush_o  = rst_n & if_id_flush_s;
    assign ctrl.id_ex_flush_o  = rst_n & id_ex_flush_s;
    assign ctrl.hold_timeout_o = timeout_q;
    assign ctrl.state_o        = state_q;

endmodule
